// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two producer FIFOs (ALU, LSB) drained round-robin,
// one registered broadcast per cycle, flushed on a branch mispredict.
module cdb_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TAG_W  = 5,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              jump_wrong,
   input  logic              alu_push,
   input  logic [DATA_W-1:0] alu_value,
   input  logic [TAG_W-1:0]  alu_rename,
   output logic              alu_full,
   input  logic              lsb_push,
   input  logic [DATA_W-1:0] lsb_value,
   input  logic [TAG_W-1:0]  lsb_rename,
   output logic              lsb_full,
   output logic              cdb_valid,
   output logic [DATA_W-1:0] cdb_value,
   output logic [TAG_W-1:0]  cdb_rename,
   output logic              overflow_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned ENT_W = TAG_W + DATA_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   // Index 0 is the ALU FIFO, index 1 the LSB FIFO.
   typedef enum logic {SrcAlu, SrcLsb} src_e;

   logic [ENT_W-1:0] mem_q    [2][DEPTH];
   logic [PTR_W-1:0] wr_ptr_q [2];
   logic [PTR_W-1:0] rd_ptr_q [2];
   logic [PTR_W:0]   cnt_q    [2];
   src_e             last_grant_q;

   logic              cdb_valid_q;
   logic [DATA_W-1:0] cdb_value_q;
   logic [TAG_W-1:0]  cdb_rename_q;
   logic              overflow_q;

   logic             active;
   logic [1:0]       push_req;
   logic [1:0]       full;
   logic [1:0]       nonempty;
   logic [1:0]       do_push;
   logic [1:0]       do_pop;
   logic [ENT_W-1:0] push_ent [2];
   logic [ENT_W-1:0] head     [2];
   logic [ENT_W-1:0] grant_ent;
   logic             overflow_set;

   assign active      = rdy && !jump_wrong;
   assign push_req    = {lsb_push, alu_push};
   assign push_ent[0] = {alu_rename, alu_value};
   assign push_ent[1] = {lsb_rename, lsb_value};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         full[i]     = (cnt_q[i] == FULL_CNT);
         nonempty[i] = (cnt_q[i] != '0);
         head[i]     = mem_q[i][rd_ptr_q[i]];
         // Full is judged on pre-edge state, so a push into a full FIFO is
         // dropped even when that FIFO is popped in the same cycle.
         do_push[i]  = active && push_req[i] && !full[i];
      end
      do_pop[0]    = active && nonempty[0] && (!nonempty[1] || last_grant_q == SrcLsb);
      do_pop[1]    = active && nonempty[1] && (!nonempty[0] || last_grant_q == SrcAlu);
      grant_ent    = do_pop[1] ? head[1] : head[0];
      overflow_set = active && |(push_req & full);
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (do_push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= push_ent[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         last_grant_q <= SrcLsb;
         cdb_valid_q  <= 1'b0;
         cdb_value_q  <= '0;
         cdb_rename_q <= '0;
         overflow_q   <= 1'b0;
      end else if (jump_wrong) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         cdb_valid_q <= 1'b0;
      end else if (!rdy) begin
         cdb_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (do_push[i]) begin
               wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
            end
            if (do_pop[i]) begin
               rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
            end
            cnt_q[i] <= cnt_q[i] + (PTR_W + 1)'(do_push[i]) - (PTR_W + 1)'(do_pop[i]);
         end
         if (|do_pop) begin
            cdb_valid_q  <= 1'b1;
            cdb_value_q  <= grant_ent[DATA_W-1:0];
            cdb_rename_q <= grant_ent[ENT_W-1:DATA_W];
            last_grant_q <= do_pop[1] ? SrcLsb : SrcAlu;
         end else begin
            cdb_valid_q <= 1'b0;
         end
         if (overflow_set) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign alu_full     = full[0];
   assign lsb_full     = full[1];
   assign cdb_valid    = cdb_valid_q;
   assign cdb_value    = cdb_value_q;
   assign cdb_rename   = cdb_rename_q;
   assign overflow_err = overflow_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin order, full/overflow, flush,
// asynchronous reset and freeze, all against hand-computed expectations.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        jump_wrong = 1'b0;
   logic        alu_push = 1'b0;
   logic [31:0] alu_value = '0;
   logic [4:0]  alu_rename = '0;
   logic        alu_full;
   logic        lsb_push = 1'b0;
   logic [31:0] lsb_value = '0;
   logic [4:0]  lsb_rename = '0;
   logic        lsb_full;
   logic        cdb_valid;
   logic [31:0] cdb_value;
   logic [4:0]  cdb_rename;
   logic        overflow_err;

   int n_chk  = 0;
   int n_pass = 0;

   cdb_arbiter #(
      .DATA_W(32),
      .TAG_W (5),
      .DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .jump_wrong  (jump_wrong),
      .alu_push    (alu_push),
      .alu_value   (alu_value),
      .alu_rename  (alu_rename),
      .alu_full    (alu_full),
      .lsb_push    (lsb_push),
      .lsb_value   (lsb_value),
      .lsb_rename  (lsb_rename),
      .lsb_full    (lsb_full),
      .cdb_valid   (cdb_valid),
      .cdb_value   (cdb_value),
      .cdb_rename  (cdb_rename),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_cdb(input string tag, input logic v, input logic [31:0] val,
                          input logic [4:0] tg);
      chk({tag, ".valid"}, 64'(cdb_valid), 64'(v));
      if (v) begin
         chk({tag, ".value"}, 64'(cdb_value), 64'(val));
         chk({tag, ".rename"}, 64'(cdb_rename), 64'(tg));
      end
   endtask

   task automatic drive(input logic ap, input logic [31:0] av, input logic [4:0] at,
                        input logic lp, input logic [31:0] lv, input logic [4:0] lt);
      alu_push   = ap;
      alu_value  = av;
      alu_rename = at;
      lsb_push   = lp;
      lsb_value  = lv;
      lsb_rename = lt;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst.valid", 64'(cdb_valid), 64'd0);
      chk("rst.value", 64'(cdb_value), 64'd0);
      chk("rst.rename", 64'(cdb_rename), 64'd0);
      chk("rst.ovf", 64'(overflow_err), 64'd0);
      chk("rst.alu_full", 64'(alu_full), 64'd0);
      chk("rst.lsb_full", 64'(lsb_full), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      step();

      // Single ALU result: one-cycle latency, one-cycle strobe
      drive(1'b1, 32'h11, 5'd3, 1'b0, '0, '0);
      step();
      idle();
      chk("t1.e1", 64'(cdb_valid), 64'd0);
      step();
      chk_cdb("t1.e2", 1'b1, 32'h11, 5'd3);
      step();
      chk("t1.e3", 64'(cdb_valid), 64'd0);

      // Fresh reset so the first tie goes to the ALU
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step();

      // Contention: alternation A0,B0,A1,...; at edge 7 an illegal LSB push
      // into a full FIFO must set overflow and be discarded
      for (int k = 0; k < 14; k++) begin
         if (k < 6) begin
            drive(1'b1, 32'hA0 + k, 5'(k), 1'b1, 32'hB0 + k, 5'(16 + k));
         end else if (k == 6) begin
            drive(1'b0, '0, '0, 1'b1, 32'hEE, 5'd31);
         end else begin
            idle();
         end
         step();
         if (k >= 1 && k <= 12) begin
            if ((k - 1) % 2 == 0) begin
               chk_cdb($sformatf("t2.rr%0d", k), 1'b1, 32'hA0 + (k - 1) / 2, 5'((k - 1) / 2));
            end else begin
               chk_cdb($sformatf("t2.rr%0d", k), 1'b1, 32'hB0 + (k - 1) / 2,
                       5'(16 + (k - 1) / 2));
            end
         end
         if (k == 5) begin
            chk("t2.lsb_full", 64'(lsb_full), 64'd1);
            chk("t2.alu_full", 64'(alu_full), 64'd0);
            chk("t2.no_ovf", 64'(overflow_err), 64'd0);
         end
         if (k == 6) begin
            chk("t3.ovf", 64'(overflow_err), 64'd1);
            chk("t3.lsb_full", 64'(lsb_full), 64'd0);
         end
      end
      chk("t2.drained", 64'(cdb_valid), 64'd0);

      // Flush with 3 ALU + 2 LSB queued plus a same-cycle ALU push
      drive(1'b1, 32'h31, 5'd1, 1'b1, 32'h41, 5'd2);
      step();
      chk("t4.e1", 64'(cdb_valid), 64'd0);
      drive(1'b1, 32'h32, 5'd1, 1'b1, 32'h42, 5'd2);
      step();
      chk_cdb("t4.e2", 1'b1, 32'h31, 5'd1);
      drive(1'b1, 32'h33, 5'd1, 1'b0, '0, '0);
      step();
      chk_cdb("t4.e3", 1'b1, 32'h41, 5'd2);
      drive(1'b1, 32'h34, 5'd1, 1'b1, 32'h43, 5'd2);
      step();
      chk_cdb("t4.e4", 1'b1, 32'h32, 5'd1);
      drive(1'b1, 32'h35, 5'd1, 1'b1, 32'h44, 5'd2);
      step();
      chk_cdb("t4.e5", 1'b1, 32'h42, 5'd2);
      drive(1'b1, 32'h36, 5'd1, 1'b0, '0, '0);
      jump_wrong = 1'b1;
      step();
      jump_wrong = 1'b0;
      idle();
      chk("t4.flush", 64'(cdb_valid), 64'd0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("t4.empty%0d", k), 64'(cdb_valid), 64'd0);
      end
      chk("t4.ovf_kept", 64'(overflow_err), 64'd1);
      chk("t4.alu_full", 64'(alu_full), 64'd0);

      // Asynchronous reset in the middle of a cycle with cdb_valid high
      drive(1'b1, 32'h51, 5'd4, 1'b1, 32'h61, 5'd5);
      step();
      idle();
      step();
      chk_cdb("t5.pre", 1'b1, 32'h51, 5'd4);
      #2;
      rst = 1'b0;
      #1;
      chk("t5.valid", 64'(cdb_valid), 64'd0);
      chk("t5.value", 64'(cdb_value), 64'd0);
      chk("t5.rename", 64'(cdb_rename), 64'd0);
      chk("t5.ovf", 64'(overflow_err), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("t5.cleared", 64'(cdb_valid), 64'd0);
      drive(1'b1, 32'h71, 5'd6, 1'b1, 32'h81, 5'd7);
      step();
      idle();
      step();
      chk_cdb("t5.tie", 1'b1, 32'h71, 5'd6);
      step();
      chk_cdb("t5.next", 1'b1, 32'h81, 5'd7);
      step();
      chk("t5.done", 64'(cdb_valid), 64'd0);

      // Freeze with both FIFOs non-empty; pushes during freeze are ignored
      drive(1'b1, 32'h91, 5'd8, 1'b1, 32'hA1, 5'd9);
      step();
      drive(1'b1, 32'h92, 5'd8, 1'b1, 32'hA2, 5'd9);
      step();
      chk_cdb("t6.pre", 1'b1, 32'h91, 5'd8);
      rdy = 1'b0;
      drive(1'b1, 32'hDD, 5'd10, 1'b1, 32'hDD, 5'd11);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("t6.frz%0d.valid", k), 64'(cdb_valid), 64'd0);
         chk($sformatf("t6.frz%0d.value", k), 64'(cdb_value), 64'h91);
      end
      rdy = 1'b1;
      idle();
      step();
      chk_cdb("t6.d1", 1'b1, 32'hA1, 5'd9);
      step();
      chk_cdb("t6.d2", 1'b1, 32'h92, 5'd8);
      step();
      chk_cdb("t6.d3", 1'b1, 32'hA2, 5'd9);
      step();
      chk("t6.d4", 64'(cdb_valid), 64'd0);
      chk("t6.ovf", 64'(overflow_err), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
